// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: DEPTH-entry byte FIFO in front of an 8N1-style serial transmitter.
// Optional build macro: UART_TX_PARITY_EN adds an even-parity bit between the
// data bits and the stop bit(s). The port list is identical in both builds.
module uart_tx_fifo #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                     CLK,
  input  logic                     NRST,
  input  logic                     wr_en,
  input  logic [7:0]               wr_data,
  input  logic                     clr_ovf,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     busy,
  output logic                     overflow,
  output logic                     uart_tx
);

  localparam int unsigned AW        = $clog2(DEPTH);
  localparam int unsigned BW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    DATA_LAST = 3'(DATA_BITS - 1);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);
  localparam logic [AW:0]   DEPTH_CNT = (AW + 1)'(DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_e;

  // FIFO storage and bookkeeping
  logic [DATA_BITS-1:0] mem_q [DEPTH];
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [AW:0]          count_q, count_d;
  logic                 ovf_q, ovf_d;
  logic                 push, pop;
  logic [DATA_BITS-1:0] rd_data;

  // Transmitter
  state_e               state_q, state_d;
  logic [BW-1:0]        baud_q, baud_d;
  logic [2:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 tx_q, tx_d;
  logic                 baud_last;
  logic                 load;
`ifdef UART_TX_PARITY_EN
  logic                 parity_q, parity_d;
`endif

  assign full     = (count_q == DEPTH_CNT);
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign overflow = ovf_q;
  assign busy     = (state_q != IDLE);
  assign uart_tx  = tx_q;
  assign rd_data  = mem_q[rd_ptr_q];

  // FIFO next-state: a write while full is still accepted if the FSM pops in the same cycle
  always_comb begin
    push     = wr_en && (!full || pop);
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    ovf_d = ovf_q;
    if (clr_ovf)
      ovf_d = 1'b0;
    if (wr_en && !push)
      ovf_d = 1'b1;
  end

  // FIFO pointers, occupancy and sticky overflow
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // FIFO storage write port (no reset needed on data)
  always_ff @(posedge CLK) begin
    if (push)
      mem_q[wr_ptr_q] <= wr_data[DATA_BITS-1:0];
  end

  // FSM next-state; tx_d is the line level for the cycle after this edge
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    pop       = 1'b0;
    load      = 1'b0;
    baud_last = (baud_q == BAUD_LAST);
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    unique case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (!empty)
          load = 1'b1;
      end
      START: begin
        if (baud_last) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
          tx_d    = shift_q[0];
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      DATA: begin
        if (baud_last) begin
          baud_d = '0;
          if (bit_q == DATA_LAST) begin
            bit_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
            tx_d    = parity_q;
`else
            state_d = STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (baud_last) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = STOP;
          tx_d    = 1'b1;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
`endif
      STOP: begin
        tx_d = 1'b1;
        if (baud_last) begin
          baud_d = '0;
          if (bit_q == STOP_LAST) begin
            bit_d = '0;
            if (!empty)
              load = 1'b1;
            else
              state_d = IDLE;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
    // Shared by IDLE and the end of STOP so back-to-back frames have no idle cycle
    if (load) begin
      pop     = 1'b1;
      shift_d = rd_data;
      state_d = START;
      baud_d  = '0;
      bit_d   = '0;
      tx_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_d = ^rd_data;
`endif
    end
  end

  // FSM state, counters, shift register and registered line output
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: queue-based frame model plus directed literal checks.
// Honours UART_TX_PARITY_EN in the same way as the design.
module tb_uart_tx_fifo;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int DBITS = 8;
  localparam int SBITS = 1;

  logic       CLK = 1'b0;
  logic       NRST, wr_en, clr_ovf;
  logic [7:0] wr_data;
  logic       full, empty, busy, overflow, uart_tx;
  logic [$clog2(DEPTH):0] count;

  uart_tx_fifo #(
    .CLKS_PER_BIT(CPB),
    .DEPTH(DEPTH),
    .DATA_BITS(DBITS),
    .STOP_BITS(SBITS)
  ) dut (
    .CLK(CLK),
    .NRST(NRST),
    .wr_en(wr_en),
    .wr_data(wr_data),
    .clr_ovf(clr_ovf),
    .full(full),
    .empty(empty),
    .count(count),
    .busy(busy),
    .overflow(overflow),
    .uart_tx(uart_tx)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: FIFO contents as a queue, the frame in flight as a queue
  // of per-cycle line levels (front = level shown during the current cycle).
  logic [7:0] m_fifo[$];
  bit         m_wave[$];
  bit         m_ovf;

  function automatic void add_bit(input bit v);
    for (int i = 0; i < CPB; i++) m_wave.push_back(v);
  endfunction

  function automatic void build_frame(input logic [7:0] b);
    add_bit(1'b0);
    for (int i = 0; i < DBITS; i++) add_bit(b[i]);
`ifdef UART_TX_PARITY_EN
    add_bit(^b[DBITS-1:0]);
`endif
    for (int i = 0; i < SBITS; i++) add_bit(1'b1);
  endfunction

  always @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      m_fifo.delete();
      m_wave.delete();
      m_ovf = 1'b0;
    end else begin
      bit do_pop, do_push;
      logic [7:0] b;
      do_pop  = (m_wave.size() <= 1) && (m_fifo.size() > 0);
      do_push = wr_en && ((m_fifo.size() < DEPTH) || do_pop);
      if (wr_en && !do_push) m_ovf = 1'b1;
      else if (clr_ovf) m_ovf = 1'b0;
      if (m_wave.size() > 0) void'(m_wave.pop_front());
      if (do_pop) begin
        b = m_fifo.pop_front();
        build_frame(b);
      end
      if (do_push) m_fifo.push_back(wr_data);
    end
  end

  // Every-cycle comparison against the model while out of reset
  always @(negedge CLK) begin
    if (NRST === 1'b1) begin
      check("tx",       uart_tx,  (m_wave.size() > 0) ? 32'(m_wave[0]) : 32'd1);
      check("busy",     busy,     32'(m_wave.size() > 0));
      check("count",    count,    32'(m_fifo.size()));
      check("empty",    empty,    32'(m_fifo.size() == 0));
      check("full",     full,     32'(m_fifo.size() == DEPTH));
      check("overflow", overflow, 32'(m_ovf));
    end
  end

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic write(input logic [7:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    @(negedge CLK);
    wr_en   = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int i;
    i = 0;
    while (i < budget && !(busy === 1'b0 && empty === 1'b1)) begin
      @(negedge CLK);
      i++;
    end
    check("idle_timeout", 32'(busy === 1'b0 && empty === 1'b1), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int pat [10];
    int i;
    pat = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
    NRST = 1'b0; wr_en = 1'b0; clr_ovf = 1'b0; wr_data = '0;
    repeat (3) tick();
    check("rst_tx",    uart_tx,  1);
    check("rst_empty", empty,    1);
    check("rst_full",  full,     0);
    check("rst_count", count,    0);
    check("rst_busy",  busy,     0);
    check("rst_ovf",   overflow, 0);
    NRST = 1'b1;
    tick();

    // Single frame of 0x55
    write(8'h55);
    check("b55_empty", empty,   0);
    check("b55_idle",  uart_tx, 1);
    for (int k = 1; k <= 41; k++) begin
      tick();
      if (k <= 40) check("b55_tx", uart_tx, 32'(pat[(k - 1) / 4]));
      check("b55_busy", busy, 32'(k <= 40));
    end

    // Back-to-back frames queued behind a frame already in flight
    write(8'h00);
    repeat (2) tick();
    write(8'hA5); check("b2b_cnt1", count, 1);
    write(8'h3C); check("b2b_cnt2", count, 2);
    write(8'hFF); check("b2b_cnt3", count, 3);
    i = 0;
    while (count === 3'd3 && i < 60) begin tick(); i++; end
    check("b2b_pop", count, 2);
    check("b2b_busy", busy, 1);
    wait_idle(300);

    // Overflow: DEPTH+1 writes while busy
    write(8'h11);
    repeat (2) tick();
    for (int j = 0; j <= DEPTH; j++) write(8'hC0 + 8'(j));
    check("ovf_full",  full,     1);
    check("ovf_count", count,    DEPTH);
    check("ovf_flag",  overflow, 1);
    clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
    check("ovf_clr",   overflow, 0);

    // Write in the same cycle the end of STOP pops a full FIFO
    i = 0;
    while (m_wave.size() != 1 && i < 100) begin tick(); i++; end
    check("wp_timeout", 32'(m_wave.size() == 1), 1);
    write(8'h5A);
    check("wp_count", count,    DEPTH);
    check("wp_full",  full,     1);
    check("wp_ovf",   overflow, 0);
    wait_idle(400);

    // Randomised traffic at a few write rates
    for (int p = 0; p < 3; p++) begin
      repeat (1000) begin
        wr_en   = ($urandom_range(0, (p == 0) ? 15 : (p == 1) ? 45 : 3) == 0);
        wr_data = 8'($urandom);
        clr_ovf = ($urandom_range(0, 63) == 0);
        tick();
      end
    end
    wr_en = 1'b0; clr_ovf = 1'b0;
    wait_idle(400);

`ifdef UART_TX_PARITY_EN
    write(8'h07);
    repeat (37) tick();
    check("parity07", uart_tx, 1);
    wait_idle(200);
`endif

    // Asynchronous reset during data bit 3 of 0x96 (bit 3 is 0)
    write(8'h96);
    write(8'h33);
    write(8'h44);
    repeat (17) tick();
    check("mid_bit3",  uart_tx, 0);
    check("mid_count", count,   2);
    #2 NRST = 1'b0;
    #1;
    check("arst_tx",    uart_tx, 1);
    check("arst_count", count,   0);
    check("arst_busy",  busy,    0);
    check("arst_empty", empty,   1);
    tick();
    NRST = 1'b1;
    repeat (5) tick();
    wait_idle(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised, buffered successor to the core's single-byte UART transmitter. It accepts bytes from the MEM-stage store path (wr_en/wr_data) into a DEPTH-entry FIFO and serialises them on uart_tx as 8N1-style frames. Status outputs let software poll full/empty/count, and a sticky overflow flag records dropped bytes. It sits between the MEM-stage store decode and the board TX pin.

Parameters:
CLKS_PER_BIT, 868, clock cycles per serial bit (100 MHz / 115200); legal range 2 or more.
DEPTH, 16, FIFO entries; power of two, 2 or more.
DATA_BITS, 8, data bits per frame (5..8); wr_data[DATA_BITS-1:0] is used.
STOP_BITS, 1, number of stop bits (1 or 2).

Ports:
CLK  in  1  system clock, rising edge.
NRST  in  1  asynchronous reset, active-low.
wr_en  in  1  push wr_data this cycle.
wr_data  in  8  byte to transmit.
clr_ovf  in  1  clear the sticky overflow flag.
full  out  1  FIFO holds DEPTH entries.
empty  out  1  FIFO holds 0 entries.
count  out  $clog2(DEPTH)+1  current FIFO occupancy.
busy  out  1  FSM is not IDLE (a frame is in flight).
overflow  out  1  sticky: a write was dropped.
uart_tx  out  1  serial line, idle high, registered output.

Behaviour:
- Reset (NRST low, asynchronous): FIFO pointers=0, count=0, empty=1, full=0, busy=0, overflow=0, uart_tx=1, FSM=IDLE, baud/bit counters=0. Asserting reset mid-frame aborts the frame immediately, with uart_tx=1 on assertion.
- FIFO: registered pointers and count. pop is internal and is asserted when the FSM loads a byte.
- A write is accepted iff wr_en && (!full || pop) in the same cycle. When wr_en && full && !pop, the byte is dropped and overflow is set at the next edge.
- overflow: a set and clr_ovf in the same cycle gives set priority (overflow stays 1).
- Simultaneous accepted write and pop: count unchanged.
- Read pointer, write pointer and count wrap modulo DEPTH (pointers) / saturate logically at DEPTH (count never exceeds DEPTH).
- FSM states: IDLE, START, DATA, STOP.
- IDLE: uart_tx=1. If !empty, pop, latch the byte into the shift register and go to START.
- START: uart_tx=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA: LSB first. Each bit is held CLKS_PER_BIT cycles. After DATA_BITS bits, go to STOP.
- STOP: uart_tx=1 for STOP_BITS*CLKS_PER_BIT cycles. At the end: if !empty, pop and go directly to START with no idle cycle between frames; otherwise go to IDLE.
- Latency: wr_en sampled at edge N into an empty FIFO with the FSM IDLE gives empty=0 after N. The FSM pops at edge N+1, and uart_tx falls after edge N+1.
- Frame length: (1+DATA_BITS+STOP_BITS)*CLKS_PER_BIT cycles.
- busy=1 from the START entry edge until the IDLE entry edge.
- Baud counter: runs 0..CLKS_PER_BIT-1 and reloads to 0 on every bit boundary and on START entry.

Optional Feature:
UART_TX_PARITY_EN
- Defined: adds a PARITY state between DATA and STOP. It drives the even parity bit (XOR of the DATA_BITS data bits) for CLKS_PER_BIT cycles. Frame length becomes (2+DATA_BITS+STOP_BITS)*CLKS_PER_BIT.
- Undefined: no PARITY state; DATA goes directly to STOP.
- The port list is identical in both builds.

Test Plan:
- Reset: hold NRST=0, then release -> uart_tx=1, empty=1, full=0, count=0, busy=0, overflow=0.
- Single byte, CLKS_PER_BIT=4: write 0x55 at edge N -> uart_tx=0 for cycles N+1..N+4, then bits 1,0,1,0,1,0,1,0 at 4 cycles each, then 1 for 4 cycles. busy drops after 40 cycles.
- Back-to-back: write 0xA5, 0x3C, 0xFF on consecutive cycles -> three contiguous frames with no idle gap. count goes 1, 2, 3 then 2 after the first pop, and empty=1 after the third pop.
- Overflow: with the FSM busy, write DEPTH+1 bytes -> full=1, count=DEPTH, overflow=1, and the last byte is never transmitted. Pulse clr_ovf -> overflow=0.
- Write with pop: with the FIFO full and STOP ending, assert wr_en in the pop cycle -> write accepted, count stays DEPTH, overflow stays 0.
- Reset mid-frame: assert NRST during DATA bit 3 -> uart_tx=1 immediately, count=0, busy=0. With UART_TX_PARITY_EN defined, byte 0x07 -> parity bit 1 before stop.
